// File: rtl/apb_i2s_tx_regs_if.sv
// APB3 slave bus bundle for the I2S transmit register block.
// Pure wiring, no latency.
// Zero-wait-state bus: the slave never holds off an access.
interface apb_i2s_tx_regs_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] paddr;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_i2s_tx_regs.sv
// APB register front end for an I2S transmitter: CTRL/STATUS regs plus a FWFT TX sample FIFO.
// Register reads are combinational; FIFO push/pop take effect at the end of the access/handshake cycle.
// Zero wait states on APB; full-FIFO pushes are dropped with pslverr; tx side is valid/ready.
module apb_i2s_tx_regs #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   apb_i2s_tx_regs_if.slave          apb,
   output logic [APB_DATA_WIDTH-1:0] tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      i2s_en
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = AW + 1;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_TXDATA = 2'd2;
   localparam logic [1:0] A_NONE   = 2'd3;

   logic                      en;
   logic                      underrun;
   logic [AW-1:0]             wptr;
   logic [AW-1:0]             rptr;
   logic [LW-1:0]             level;
   logic [APB_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic       access, wr, rd;
   logic [1:0] sel;
   logic       empty, full;
   logic       pop, push, push_drop;
   logic       ctrl_wr, fifo_clr, underrun_set;
   logic [APB_DATA_WIDTH-1:0] status;

   // Address bits outside [3:2] and CTRL write bits above 2 carry no meaning.
   logic unused_bits;
   assign unused_bits = ^{apb.paddr[APB_ADDR_WIDTH-1:4], apb.paddr[1:0],
                          apb.pwdata[APB_DATA_WIDTH-1:3]};

   assign access = apb.psel & apb.penable;
   assign wr     = access & apb.pwrite;
   assign rd     = access & ~apb.pwrite;
   assign sel    = apb.paddr[3:2];

   assign empty    = (level == '0);
   assign full     = (level == LW'(FIFO_DEPTH));
   assign tx_valid = en & ~empty;
   assign tx_data  = mem[rptr];
   assign i2s_en   = en;

   // A pop in the same cycle frees the slot, so a push into a full FIFO is then legal.
   assign pop          = tx_valid & tx_ready;
   assign push         = wr & (sel == A_TXDATA) & (~full | pop);
   assign push_drop    = wr & (sel == A_TXDATA) & full & ~pop;
   assign ctrl_wr      = wr & (sel == A_CTRL);
   assign fifo_clr     = ctrl_wr & apb.pwdata[1];
   assign underrun_set = en & empty & tx_ready;

   // STATUS word assembled from live state.
   always_comb begin
      status       = '0;
      status[0]    = empty;
      status[1]    = full;
      status[2]    = underrun;
      status[15:8] = 8'(level);
   end

   // APB response: zero wait states, error and read data only inside access cycles.
   always_comb begin
      apb.pready  = access & ~rst;
      apb.pslverr = 1'b0;
      apb.prdata  = '0;
      if (access && !rst) begin
         apb.pslverr = (sel == A_NONE) | (wr & (sel == A_STATUS)) | push_drop;
         if (rd) begin
            case (sel)
               A_CTRL:   apb.prdata[0] = en;
               A_STATUS: apb.prdata    = status;
               default:  apb.prdata    = '0;
            endcase
         end
      end
   end

   // Control, sticky underrun flag and FIFO pointers/level; clear overrides any pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en       <= 1'b0;
         underrun <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
      end else begin
         if (ctrl_wr)
            en <= apb.pwdata[0];
         // A fresh underrun event wins over a same-cycle clear so it is never lost.
         if (underrun_set)
            underrun <= 1'b1;
         else if (ctrl_wr && apb.pwdata[2])
            underrun <= 1'b0;
         if (fifo_clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
         end else begin
            if (push)
               wptr <= wptr + 1'b1;
            if (pop)
               rptr <= rptr + 1'b1;
            case ({push, pop})
               2'b10:   level <= level + 1'b1;
               2'b01:   level <= level - 1'b1;
               default: level <= level;
            endcase
         end
      end
   end

   // Sample storage, not reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= apb.pwdata;
   end

endmodule

// File: tb/tb_apb_i2s_tx_regs.sv
// Directed self-checking bench for apb_i2s_tx_regs.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
// Each test task drives its scenario and compares against hand-computed values.
module tb_apb_i2s_tx_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        i2s_en;

   int cmp = 0;
   int bad = 0;

   apb_i2s_tx_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

   apb_i2s_tx_regs #(
      .APB_ADDR_WIDTH(32),
      .APB_DATA_WIDTH(32),
      .FIFO_DEPTH(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .apb      (apb),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .i2s_en   (i2s_en)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] CTRL   = 32'h0;
   localparam logic [31:0] STATUS = 32'h4;
   localparam logic [31:0] TXDATA = 32'h8;
   localparam logic [31:0] NONE   = 32'hC;

   // Bus drivers: called just after a rising edge, return just after the access edge.
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                            output logic err, output logic rdy);
      apb.paddr = addr; apb.pwdata = data; apb.pwrite = 1'b1;
      apb.psel = 1'b1; apb.penable = 1'b0;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      @(negedge clk);
      err = apb.pslverr; rdy = apb.pready;
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic err);
      apb.paddr = addr; apb.pwrite = 1'b0;
      apb.psel = 1'b1; apb.penable = 1'b0;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      @(negedge clk);
      data = apb.prdata; err = apb.pslverr;
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic e;
      rst = 1'b1; tx_ready = 1'b1;
      apb.paddr = NONE; apb.pwdata = '0; apb.pwrite = 1'b0;
      apb.psel = 1'b1; apb.penable = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (apb.pready !== 1'b0) begin bad++; $display("FAIL rst_pready: got %b expected 0", apb.pready); end
      cmp++;
      if (apb.pslverr !== 1'b0) begin bad++; $display("FAIL rst_pslverr: got %b expected 0", apb.pslverr); end
      cmp++;
      if (apb.prdata !== 32'h0) begin bad++; $display("FAIL rst_prdata: got %h expected 0", apb.prdata); end
      cmp++;
      if ({tx_valid, i2s_en} !== 2'b00) begin bad++; $display("FAIL rst_tx: got %b expected 00", {tx_valid, i2s_en}); end
      cmp++;
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0; tx_ready = 1'b0; rst = 1'b0;
      apb_read(STATUS, d, e);
      if (d !== 32'h1 || e !== 1'b0) begin bad++; $display("FAIL reset_status: got %h/%b expected 00000001/0", d, e); end
      cmp++;
      apb_read(CTRL, d, e);
      if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h expected 0", d); end
      cmp++;
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
      cmp++;
   endtask

   task automatic test_handshake();
      logic [31:0] d; logic e, r;
      // Setup phase of a read must show no ready, error or data.
      apb.paddr = STATUS; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
      @(negedge clk);
      if ({apb.pready, apb.pslverr, apb.prdata} !== 34'h0) begin
         bad++; $display("FAIL setup_phase: got %b/%b/%h expected 0/0/0", apb.pready, apb.pslverr, apb.prdata);
      end
      cmp++;
      @(posedge clk); #1;
      apb.psel = 1'b0;
      apb_write(CTRL, 32'h1, e, r);
      if ({r, e} !== 2'b10) begin bad++; $display("FAIL ctrl_write_resp: got rdy=%b err=%b expected 1/0", r, e); end
      cmp++;
      if (i2s_en !== 1'b1) begin bad++; $display("FAIL i2s_en_set: got %b expected 1", i2s_en); end
      cmp++;
      apb_read(TXDATA, d, e);
      if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL txdata_read: got %h/%b expected 0/0", d, e); end
      cmp++;
   endtask

   task automatic test_fill();
      logic [31:0] d; logic e, r;
      for (int i = 1; i <= 8; i++) begin
         apb_write(TXDATA, 32'hA5A5_0000 + 32'(i), e, r);
         if (e !== 1'b0) begin bad++; $display("FAIL fill_err%0d: got %b expected 0", i, e); end
         cmp++;
      end
      apb_read(STATUS, d, e);
      if (d !== 32'h0000_0802) begin bad++; $display("FAIL full_status: got %h expected 00000802", d); end
      cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 32'hA5A5_0001) begin
         bad++; $display("FAIL full_head: got %b/%h expected 1/a5a50001", tx_valid, tx_data);
      end
      cmp++;
      apb_write(TXDATA, 32'hDEAD_BEEF, e, r);
      if (e !== 1'b1) begin bad++; $display("FAIL overflow_err: got %b expected 1", e); end
      cmp++;
      apb_read(STATUS, d, e);
      if (d !== 32'h0000_0802) begin bad++; $display("FAIL overflow_level: got %h expected 00000802", d); end
      cmp++;
   endtask

   task automatic test_drain();
      logic [31:0] d; logic e;
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (tx_valid !== 1'b1 || tx_data !== 32'hA5A5_0000 + 32'(i)) begin
            bad++; $display("FAIL drain%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, 32'hA5A5_0000 + 32'(i));
         end
         cmp++;
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL drained_valid: got %b expected 0", tx_valid); end
      cmp++;
      apb_read(STATUS, d, e);
      if (d !== 32'h1) begin bad++; $display("FAIL drained_status: got %h expected 00000001", d); end
      cmp++;
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d; logic e, r;
      logic [31:0] exp_q[$];
      for (int i = 0; i < 8; i++) begin
         apb_write(TXDATA, 32'hB000_0000 + 32'(i), e, r);
      end
      // Push into the full FIFO in the same cycle the transmitter pops.
      apb.paddr = TXDATA; apb.pwdata = 32'h1234; apb.pwrite = 1'b1;
      apb.psel = 1'b1; apb.penable = 1'b0;
      @(posedge clk); #1;
      apb.penable = 1'b1; tx_ready = 1'b1;
      @(negedge clk);
      e = apb.pslverr;
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; tx_ready = 1'b0;
      if (e !== 1'b0) begin bad++; $display("FAIL pushpop_err: got %b expected 0", e); end
      cmp++;
      apb_read(STATUS, d, e);
      if (d !== 32'h0000_0802) begin bad++; $display("FAIL pushpop_level: got %h expected 00000802", d); end
      cmp++;
      for (int i = 1; i < 8; i++) exp_q.push_back(32'hB000_0000 + 32'(i));
      exp_q.push_back(32'h1234);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tx_data !== exp_q[i]) begin bad++; $display("FAIL pushpop_order%0d: got %h expected %h", i, tx_data, exp_q[i]); end
         cmp++;
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      apb_read(STATUS, d, e);
      if (d !== 32'h1) begin bad++; $display("FAIL pushpop_empty: got %h expected 00000001", d); end
      cmp++;
   endtask

   task automatic test_underrun();
      logic [31:0] d; logic e, r;
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      apb_read(STATUS, d, e);
      if (d !== 32'h5) begin bad++; $display("FAIL underrun_set: got %h expected 00000005", d); end
      cmp++;
      apb_write(CTRL, 32'h5, e, r);
      apb_read(STATUS, d, e);
      if (d !== 32'h1) begin bad++; $display("FAIL underrun_clear: got %h expected 00000001", d); end
      cmp++;
      apb_read(CTRL, d, e);
      if (d !== 32'h1) begin bad++; $display("FAIL underrun_ctrl: got %h expected 00000001", d); end
      cmp++;
   endtask

   task automatic test_clear_and_errors();
      logic [31:0] d; logic e, r;
      for (int i = 1; i <= 3; i++) apb_write(TXDATA, 32'hC000_0000 + 32'(i), e, r);
      apb_read(STATUS, d, e);
      if (d !== 32'h0000_0300) begin bad++; $display("FAIL level3: got %h expected 00000300", d); end
      cmp++;
      apb_write(CTRL, 32'h3, e, r);
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b expected 0", tx_valid); end
      cmp++;
      apb_read(STATUS, d, e);
      if (d !== 32'h1) begin bad++; $display("FAIL clr_status: got %h expected 00000001", d); end
      cmp++;
      apb_read(CTRL, d, e);
      if (d !== 32'h1) begin bad++; $display("FAIL clr_ctrl_read: got %h expected 00000001", d); end
      cmp++;
      apb_read(NONE, d, e);
      if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h/%b expected 0/1", d, e); end
      cmp++;
      apb_write(NONE, 32'hFFFF_FFFF, e, r);
      if (e !== 1'b1) begin bad++; $display("FAIL unmapped_write: got %b expected 1", e); end
      cmp++;
      apb_write(STATUS, 32'hFFFF_FFFF, e, r);
      if (e !== 1'b1) begin bad++; $display("FAIL status_write: got %b expected 1", e); end
      cmp++;
      apb_read(STATUS, d, e);
      if (d !== 32'h1 || i2s_en !== 1'b1) begin bad++; $display("FAIL no_state_change: got %h/%b expected 00000001/1", d, i2s_en); end
      cmp++;
   endtask

   task automatic test_en_hold();
      logic [31:0] d; logic e, r;
      apb_write(TXDATA, 32'hD1, e, r);
      apb_write(TXDATA, 32'hD2, e, r);
      apb_write(CTRL, 32'h0, e, r);
      tx_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (tx_valid !== 1'b0) begin bad++; $display("FAIL hold_valid: got %b expected 0", tx_valid); end
         cmp++;
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      apb_read(STATUS, d, e);
      if (d !== 32'h0000_0200) begin bad++; $display("FAIL hold_status: got %h expected 00000200", d); end
      cmp++;
      apb_write(CTRL, 32'h1, e, r);
      if (tx_valid !== 1'b1 || tx_data !== 32'hD1) begin bad++; $display("FAIL hold_resume: got %b/%h expected 1/000000d1", tx_valid, tx_data); end
      cmp++;
   endtask

   task automatic test_mid_reset();
      logic [31:0] d; logic e, r;
      apb.paddr = TXDATA; apb.pwdata = 32'hEEEE; apb.pwrite = 1'b1;
      apb.psel = 1'b1; apb.penable = 1'b0;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      #2 rst = 1'b1;
      @(negedge clk);
      if ({apb.pready, tx_valid} !== 2'b00) begin bad++; $display("FAIL midrst_outputs: got %b expected 00", {apb.pready, tx_valid}); end
      cmp++;
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; rst = 1'b0;
      apb_read(STATUS, d, e);
      if (d !== 32'h1) begin bad++; $display("FAIL midrst_status: got %h expected 00000001", d); end
      cmp++;
      apb_write(CTRL, 32'h1, e, r);
      if ({r, e} !== 2'b10) begin bad++; $display("FAIL postrst_write: got rdy=%b err=%b expected 1/0", r, e); end
      cmp++;
      apb_read(CTRL, d, e);
      if (d !== 32'h1) begin bad++; $display("FAIL postrst_ctrl: got %h expected 00000001", d); end
      cmp++;
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_fill();
      test_drain();
      test_full_push_pop();
      test_underrun();
      test_clear_and_errors();
      test_en_hold();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule
